// File: rtl/ceespu_dmem_responder.sv
// CPU data-memory responder: latches one request, strobes the SRAM for
// WAIT_STATES+1 cycles, returns read data and stalls the CPU meanwhile.
module ceespu_dmem_responder #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic [15:0] I_dmemAddress,
    input  logic [31:0] I_dmemWData,
    input  logic        I_dmemE,
    input  logic [3:0]  I_dmemWe,
    output logic [31:0] O_dmemData,
    output logic        O_dmemBusy,
    output logic [13:0] O_sramAddr,
    output logic [31:0] O_sramWData,
    output logic [3:0]  O_sramBe,
    output logic        O_sramCe,
    output logic        O_sramWe,
    input  logic [31:0] I_sramRData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] data_q, data_d;
    logic        accept;
    logic        in_access;
    logic        unused_addr_lsbs;

    // Byte offset is irrelevant to a word-wide SRAM.
    assign unused_addr_lsbs = ^I_dmemAddress[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        data_d  = data_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (I_dmemE) accept = 1'b1;
                else         state_d = IDLE;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    if (we_q == 4'b0000) data_d = I_sramRData;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = ACCESS;
            cnt_d   = WAIT_INIT;
            addr_d  = I_dmemAddress[15:2];
            wdata_d = I_dmemWData;
            we_d    = I_dmemWe;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 14'd0;
            wdata_q <= 32'd0;
            we_q    <= 4'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            data_q  <= data_d;
        end
    end

    // Busy is raised in the request cycle itself so the CPU stalls before
    // the holding registers are even loaded.
    assign in_access   = (state_q == ACCESS);
    assign O_dmemBusy  = !I_rst && (accept || in_access);
    assign O_dmemData  = data_q;
    assign O_sramAddr  = addr_q;
    assign O_sramWData = wdata_q;
    assign O_sramCe    = in_access;
    assign O_sramWe    = in_access && (we_q != 4'b0000);
    assign O_sramBe    = !in_access ? 4'b0000 :
                         (we_q != 4'b0000) ? we_q : 4'b1111;

endmodule

// File: tb/tb_ceespu_dmem_responder.sv
// Bench for ceespu_dmem_responder: directed vector table on a WAIT_STATES=2
// instance, a WAIT_STATES=0 sequence, and random traffic against a reference.
module tb_ceespu_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, e;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  we;

    // index 0: WAIT_STATES=0 instance, index 1: WAIT_STATES=2 instance
    logic        bsy [2];
    logic        ce  [2];
    logic        swe [2];
    logic [3:0]  be  [2];
    logic [13:0] sa  [2];
    logic [31:0] swd [2];
    logic [31:0] dout[2];
    logic [31:0] rd  [2];

    logic [31:0] env_mem [2][16384];
    logic [31:0] ref_mem [2][16384];

    assign rd[0] = env_mem[0][sa[0]];
    assign rd[1] = env_mem[1][sa[1]];

    ceespu_dmem_responder #(.WAIT_STATES(0)) dut0 (
        .I_clk(clk), .I_rst(rst), .I_dmemAddress(addr), .I_dmemWData(wd),
        .I_dmemE(e), .I_dmemWe(we), .O_dmemData(dout[0]), .O_dmemBusy(bsy[0]),
        .O_sramAddr(sa[0]), .O_sramWData(swd[0]), .O_sramBe(be[0]),
        .O_sramCe(ce[0]), .O_sramWe(swe[0]), .I_sramRData(rd[0])
    );

    ceespu_dmem_responder #(.WAIT_STATES(2)) dut2 (
        .I_clk(clk), .I_rst(rst), .I_dmemAddress(addr), .I_dmemWData(wd),
        .I_dmemE(e), .I_dmemWe(we), .O_dmemData(dout[1]), .O_dmemBusy(bsy[1]),
        .O_sramAddr(sa[1]), .O_sramWData(swd[1]), .O_sramBe(be[1]),
        .O_sramCe(ce[1]), .O_sramWe(swe[1]), .I_sramRData(rd[1])
    );

    // Reference: a transfer is a count of remaining SRAM cycles plus the
    // captured request; read data lands when the count reaches zero.
    int          acc_left[2];
    int          wst[2];
    logic [15:0] h_addr[2];
    logic [31:0] h_wd[2];
    logic [3:0]  h_we[2];
    logic [31:0] m_dout[2];

    int total = 0;
    int bad   = 0;
    bit mdl_on = 1'b0;

    typedef struct {
        bit          r;
        bit          en;
        logic [15:0] a;
        logic [31:0] w;
        logic [3:0]  m;
        bit          xb;
        bit          xce;
        bit          xwe;
        logic [3:0]  xbe;
        logic [31:0] xd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(bit r, bit en, logic [15:0] a, logic [31:0] w,
                                logic [3:0] m, bit xb, bit xce, bit xwe,
                                logic [3:0] xbe, logic [31:0] xd);
        vec_t v;
        v.r = r; v.en = en; v.a = a; v.w = w; v.m = m;
        v.xb = xb; v.xce = xce; v.xwe = xwe; v.xbe = xbe; v.xd = xd;
        return v;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(bit r, bit en, logic [15:0] a, logic [31:0] w, logic [3:0] m);
        rst = r; e = en; addr = a; wd = w; we = m;
    endtask

    task automatic model_check(int i);
        bit         acc;
        logic [3:0] xbe;
        acc = (acc_left[i] > 0);
        xbe = !acc ? 4'h0 : ((h_we[i] != 4'h0) ? h_we[i] : 4'hF);
        chk($sformatf("m%0d_busy", i), 32'(bsy[i]), 32'(!rst && (acc || e)));
        chk($sformatf("m%0d_ce", i),   32'(ce[i]),   32'(acc));
        chk($sformatf("m%0d_we", i),   32'(swe[i]),  32'(acc && (h_we[i] != 4'h0)));
        chk($sformatf("m%0d_be", i),   32'(be[i]),   32'(xbe));
        chk($sformatf("m%0d_addr", i), 32'(sa[i]),   32'(h_addr[i][15:2]));
        chk($sformatf("m%0d_wdata", i), swd[i],      h_wd[i]);
        chk($sformatf("m%0d_data", i), dout[i],      m_dout[i]);
    endtask

    task automatic model_step(int i);
        if (acc_left[i] > 0 && h_we[i] != 4'h0)
            ref_mem[i][h_addr[i][15:2]] = merge(ref_mem[i][h_addr[i][15:2]], h_wd[i], h_we[i]);
        if (rst) begin
            acc_left[i] = 0; h_addr[i] = '0; h_wd[i] = '0; h_we[i] = '0; m_dout[i] = '0;
        end else if (acc_left[i] > 0) begin
            acc_left[i]--;
            if (acc_left[i] == 0 && h_we[i] == 4'h0)
                m_dout[i] = ref_mem[i][h_addr[i][15:2]];
        end else if (e) begin
            h_addr[i] = addr; h_wd[i] = wd; h_we[i] = we;
            acc_left[i] = wst[i] + 1;
        end
    endtask

    // Negedge: compare against the model, then let the SRAM take any write.
    task automatic half();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (mdl_on) model_check(i);
            if (ce[i] && swe[i])
                env_mem[i][sa[i]] = merge(env_mem[i][sa[i]], swd[i], be[i]);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        if (mdl_on)
            for (int i = 0; i < 2; i++) model_step(i);
        #1;
    endtask

    initial begin
        wst[0] = 0; wst[1] = 2;
        for (int i = 0; i < 2; i++) begin
            acc_left[i] = 0; h_addr[i] = '0; h_wd[i] = '0; h_we[i] = '0; m_dout[i] = '0;
            for (int j = 0; j < 16384; j++) begin
                env_mem[i][j] = 32'(j) * 32'h9E3779B9;
                ref_mem[i][j] = 32'(j) * 32'h9E3779B9;
            end
            env_mem[i][16'h0010] = 32'hDEADBEEF; ref_mem[i][16'h0010] = 32'hDEADBEEF;
            env_mem[i][16'h0020] = 32'h12345678; ref_mem[i][16'h0020] = 32'h12345678;
        end

        drive(1, 0, 16'h0, 32'h0, 4'h0);
        half(); edge_();
        half(); edge_();
        mdl_on = 1'b1;

        // reset blocks acceptance; single read
        vq.push_back(mk(1, 1, 16'h0040, 32'h0, 4'h0, 0, 0, 0, 4'h0, 32'h0));
        vq.push_back(mk(0, 1, 16'h0040, 32'h0, 4'h0, 1, 0, 0, 4'h0, 32'h0));
        repeat (3) vq.push_back(mk(0, 1, 16'h0040, 32'h0, 4'h0, 1, 1, 0, 4'hF, 32'h0));
        vq.push_back(mk(0, 0, 16'h0040, 32'h0, 4'h0, 0, 0, 0, 4'h0, 32'hDEADBEEF));
        vq.push_back(mk(0, 0, 16'h0040, 32'h0, 4'h0, 0, 0, 0, 4'h0, 32'hDEADBEEF));
        // byte write into lane 2
        vq.push_back(mk(0, 1, 16'h0042, 32'h00AB0000, 4'h4, 1, 0, 0, 4'h0, 32'hDEADBEEF));
        repeat (3) vq.push_back(mk(0, 1, 16'h0042, 32'h00AB0000, 4'h4, 1, 1, 1, 4'h4, 32'hDEADBEEF));
        vq.push_back(mk(0, 0, 16'h0042, 32'h00AB0000, 4'h4, 0, 0, 0, 4'h0, 32'hDEADBEEF));
        // back-to-back write then read, re-accepted straight from RESP
        vq.push_back(mk(0, 1, 16'h0044, 32'h11223344, 4'hF, 1, 0, 0, 4'h0, 32'hDEADBEEF));
        repeat (3) vq.push_back(mk(0, 1, 16'h0044, 32'h11223344, 4'hF, 1, 1, 1, 4'hF, 32'hDEADBEEF));
        vq.push_back(mk(0, 1, 16'h0044, 32'h0, 4'h0, 1, 0, 0, 4'h0, 32'hDEADBEEF));
        repeat (3) vq.push_back(mk(0, 1, 16'h0044, 32'h0, 4'h0, 1, 1, 0, 4'hF, 32'hDEADBEEF));
        vq.push_back(mk(0, 0, 16'h0044, 32'h0, 4'h0, 0, 0, 0, 4'h0, 32'h11223344));
        // read back the byte-merged word
        vq.push_back(mk(0, 1, 16'h0040, 32'h0, 4'h0, 1, 0, 0, 4'h0, 32'h11223344));
        repeat (3) vq.push_back(mk(0, 1, 16'h0040, 32'h0, 4'h0, 1, 1, 0, 4'hF, 32'h11223344));
        vq.push_back(mk(0, 0, 16'h0040, 32'h0, 4'h0, 0, 0, 0, 4'h0, 32'hDEABBEEF));
        // reset on the second ACCESS cycle of a read
        vq.push_back(mk(0, 1, 16'h0044, 32'h0, 4'h0, 1, 0, 0, 4'h0, 32'hDEABBEEF));
        vq.push_back(mk(0, 1, 16'h0044, 32'h0, 4'h0, 1, 1, 0, 4'hF, 32'hDEABBEEF));
        vq.push_back(mk(1, 1, 16'h0044, 32'h0, 4'h0, 0, 1, 0, 4'hF, 32'hDEABBEEF));
        vq.push_back(mk(0, 0, 16'h0044, 32'h0, 4'h0, 0, 0, 0, 4'h0, 32'h0));

        foreach (vq[k]) begin
            drive(vq[k].r, vq[k].en, vq[k].a, vq[k].w, vq[k].m);
            half();
            chk($sformatf("t%0d_busy", k), 32'(bsy[1]), 32'(vq[k].xb));
            chk($sformatf("t%0d_ce", k),   32'(ce[1]),  32'(vq[k].xce));
            chk($sformatf("t%0d_we", k),   32'(swe[1]), 32'(vq[k].xwe));
            chk($sformatf("t%0d_be", k),   32'(be[1]),  32'(vq[k].xbe));
            chk($sformatf("t%0d_data", k), dout[1],     vq[k].xd);
            edge_();
        end

        // zero wait states: busy two cycles, single ACCESS cycle
        drive(0, 1, 16'h0080, 32'h0, 4'h0);
        half();
        chk("w0_req_busy", 32'(bsy[0]), 32'd1);
        chk("w0_req_ce",   32'(ce[0]),  32'd0);
        edge_();
        half();
        chk("w0_acc_busy", 32'(bsy[0]), 32'd1);
        chk("w0_acc_ce",   32'(ce[0]),  32'd1);
        chk("w0_acc_be",   32'(be[0]),  32'hF);
        chk("w0_acc_addr", 32'(sa[0]),  32'h20);
        edge_();
        drive(0, 0, 16'h0080, 32'h0, 4'h0);
        half();
        chk("w0_resp_busy", 32'(bsy[0]), 32'd0);
        chk("w0_resp_ce",   32'(ce[0]),  32'd0);
        chk("w0_resp_data", dout[0],     32'h12345678);
        edge_();
        repeat (2) begin half(); edge_(); end

        // long idle: nothing moves
        for (int c = 0; c < 20; c++) begin
            half();
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("idle%0d_busy%0d", c, i), 32'(bsy[i]), 32'd0);
                chk($sformatf("idle%0d_ce%0d", c, i),   32'(ce[i]),  32'd0);
                chk($sformatf("idle%0d_data%0d", c, i), dout[i],     32'h12345678);
            end
            edge_();
        end

        // random traffic, reference model compares every cycle
        for (int c = 0; c < 2000; c++) begin
            drive($urandom_range(63) == 0, $urandom_range(3) != 0,
                  16'(($urandom_range(15) << 2) | $urandom_range(3)), $urandom,
                  ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0);
            half();
            edge_();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
